// File: rtl/period_meter.sv
// period_meter: measures the period and high time of a slow, asynchronous
// square wave in system clock cycles. The input is first synchronised, then
// edge-detected. Results are published with a one-cycle valid strobe, and a
// sticky timeout flag is raised when the counter saturates.
module period_meter #(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       high_sh_q, high_sh_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_q, high_d;
  logic                   valid_q, valid_d;
  logic                   timeout_q, timeout_d;

  logic                   sig_s;
  logic                   rise;
  logic                   fall;

  // The last synchroniser stage is the clean in-domain copy of sig_in;
  // edge_q holds its value from the previous cycle for edge detection.
  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~edge_q;
  assign fall  = ~sig_s & edge_q;

  // Synchroniser shift and edge-detect register next-state.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
    edge_d = sig_s;
  end

  // Measurement FSM: next state, counter, shadow and result registers.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_sh_d = high_sh_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (!en) begin
      // Disable overrides any edge seen in the same cycle; results are held.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end

        ARM: begin
          // The first rising edge only starts the count; nothing is published.
          if (rise) begin
            cnt_d     = CNT_ONE;
            high_sh_d = '0;
            state_d   = MEASURE;
          end
        end

        MEASURE: begin
          if (rise) begin
            // Rise wins over saturation so a period of exactly CNT_MAX
            // is still reported instead of timing out.
            period_d  = cnt_q;
            high_d    = high_sh_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
            high_sh_d = '0;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
            if (fall) begin
              high_sh_d = cnt_q;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      edge_q    <= 1'b0;
      cnt_q     <= '0;
      high_sh_q <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      edge_q    <= edge_d;
      cnt_q     <= cnt_d;
      high_sh_q <= high_sh_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (CNT_W=8 so saturation is reachable).
// Inputs change on the falling clock edge; outputs are sampled there too.
// Edge timing: sig_in driven after edge e is sampled at e+1 and acted on by
// the FSM at edge e+3, so the k-th valid of a wave started after edge e0
// with period P appears after edge e0 + 3 + P*(k+1).
module tb_period_meter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       sig_in;
  logic [7:0] period_o;
  logic [7:0] high_o;
  logic       valid_o;
  logic       timeout_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned edge_n = 0;

  int unsigned q_edge[$];
  int unsigned q_per[$];
  int unsigned q_hi[$];

  int unsigned e0;

  period_meter #(
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sig_in   (sig_in),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Log every valid strobe with the index of the edge that produced it.
  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      q_edge.push_back(edge_n);
      q_per.push_back(int'(period_o));
      q_hi.push_back(int'(high_o));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    q_edge.delete();
    q_per.delete();
    q_hi.delete();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = 1'b1;
      tick(hi);
      sig_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic check_valids(input string tag, input int unsigned base, input int nexp,
                              input int p, input int h);
    check({tag, "_count"}, q_edge.size(), nexp);
    for (int i = 0; i < q_edge.size(); i++) begin
      check({tag, "_edge"}, q_edge[i], base + 3 + p * (i + 1));
      check({tag, "_period"}, q_per[i], p);
      check({tag, "_high"}, q_hi[i], h);
    end
  endtask

  task automatic reenable();
    en = 1'b0;
    tick(2);
    en = 1'b1;
    tick(2);
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    tick(3);
    check("rst_period", period_o, 0);
    check("rst_high", high_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_timeout", timeout_o, 0);

    rst_n = 1'b1;
    en    = 1'b1;
    tick(2);
    clear_log();

    // 5 high / 5 low: first rise arms, then one valid per period.
    e0 = edge_n;
    wave(5, 5, 5);
    check_valids("sq55", e0, 4, 10, 5);

    // 3 high / 7 low.
    reenable();
    e0 = edge_n;
    wave(3, 7, 4);
    check_valids("sq37", e0, 3, 10, 3);

    // Single-cycle pulses every 20 cycles.
    reenable();
    e0 = edge_n;
    wave(1, 19, 4);
    check_valids("pulse20", e0, 3, 20, 1);

    // Enable dropped on the very cycle a rise is acted on, held low across
    // another rise, then raised: results held, two fresh rises needed.
    reenable();
    e0 = edge_n;
    wave(5, 5, 3);
    check_valids("en_pre", e0, 2, 10, 5);
    clear_log();
    sig_in = 1'b1;
    tick(2);
    en = 1'b0;
    tick(3);
    sig_in = 1'b0;
    tick(5);
    check("en_off_period_held", period_o, 10);
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(2);
    check("en_off_period_held2", period_o, 10);
    check("en_off_high_held", high_o, 5);
    check("en_off_no_valid", q_edge.size(), 0);
    en = 1'b1;
    tick(3);
    e0 = edge_n;
    wave(5, 5, 3);
    check_valids("en_post", e0, 2, 10, 5);

    // Rise arriving exactly when the counter reaches 255: reported, no timeout.
    reenable();
    e0 = edge_n;
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(250);
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(5);
    check("satrise_count", q_edge.size(), 1);
    if (q_edge.size() >= 1) begin
      check("satrise_edge", q_edge[0], e0 + 258);
      check("satrise_period", q_per[0], 255);
      check("satrise_high", q_hi[0], 5);
    end
    check("satrise_timeout", timeout_o, 0);

    // Held low after arming: timeout raised on edge e0+258, results held.
    reenable();
    e0 = edge_n;
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(252);
    check("to_before", timeout_o, 0);
    tick(1);
    check("to_set", timeout_o, 1);
    check("to_period_held", period_o, 255);
    check("to_high_held", high_o, 5);
    check("to_no_valid", q_edge.size(), 0);
    e0 = edge_n;
    sig_in = 1'b1;
    tick(5);
    check("to_sticky_after_arm", timeout_o, 1);
    sig_in = 1'b0;
    tick(5);
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(5);
    check_valids("to_recover", e0, 1, 10, 5);
    check("to_cleared", timeout_o, 0);

    // One-cycle reset mid-measurement.
    sig_in = 1'b1;
    tick(5);
    sig_in = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    clear_log();
    check("mid_rst_period", period_o, 0);
    check("mid_rst_high", high_o, 0);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_timeout", timeout_o, 0);
    e0 = edge_n;
    wave(5, 5, 3);
    check_valids("post_rst", e0, 2, 10, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
